// File: rtl/mc_residual_stream.sv
// Motion-compensation stage: fetches an edge-clamped predicted block and streams
// the residual (or the prediction) one row per beat, with a running block SAD.
module mc_residual_stream #(
  parameter int unsigned MB_SIZE        = 4,
  parameter int unsigned PIXEL_WIDTH    = 8,
  parameter int unsigned REF_FRAME_SIZE = 8,
  parameter int unsigned MV_WIDTH       = 6
) (
  input  logic                                                          clk,
  input  logic                                                          reset,
  input  logic                                                          src_valid,
  output logic                                                          src_ready,
  input  logic [$clog2(REF_FRAME_SIZE)-1:0]                             mb_x,
  input  logic [$clog2(REF_FRAME_SIZE)-1:0]                             mb_y,
  input  logic signed [MV_WIDTH-1:0]                                    mv_x,
  input  logic signed [MV_WIDTH-1:0]                                    mv_y,
  input  logic                                                          mode,
  input  logic [REF_FRAME_SIZE-1:0][REF_FRAME_SIZE-1:0][PIXEL_WIDTH-1:0] ref_frame,
  input  logic [MB_SIZE-1:0][MB_SIZE-1:0][PIXEL_WIDTH-1:0]               curr_mb,
  output logic                                                          dst_valid,
  input  logic                                                          dst_ready,
  output logic [$clog2(MB_SIZE)-1:0]                                    dst_row,
  output logic                                                          dst_last,
  output logic [MB_SIZE-1:0][PIXEL_WIDTH:0]                             residual_row,
  output logic [PIXEL_WIDTH+2*$clog2(MB_SIZE)-1:0]                      sad
);

  localparam int unsigned FW = $clog2(REF_FRAME_SIZE);
  localparam int unsigned RW = $clog2(MB_SIZE);
  localparam int unsigned DW = PIXEL_WIDTH + 1;
  localparam int unsigned SW = PIXEL_WIDTH + 2 * RW;
  // Address width covers origin + MV + in-block offset without overflow.
  localparam int unsigned AW = MV_WIDTH + FW + 2;
  localparam logic signed [AW-1:0] COORD_MAX = AW'(REF_FRAME_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_OUT} state_t;

  state_t                                        state_q, state_d;
  logic                                          src_ready_q, src_ready_d;
  logic                                          dst_valid_q, dst_valid_d;
  logic                                          dst_last_q, dst_last_d;
  logic [RW-1:0]                                 row_q, row_d;
  logic [MB_SIZE-1:0][DW-1:0]                    res_q, res_d;
  logic [SW-1:0]                                 sad_q, sad_d;
  logic [FW-1:0]                                 mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic signed [MV_WIDTH-1:0]                    mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic                                          mode_q, mode_d;
  logic [MB_SIZE-1:0][MB_SIZE-1:0][PIXEL_WIDTH-1:0] curr_q, curr_d;

  logic [RW-1:0]              row_sel;
  logic signed [AW-1:0]       x_s, y_s;
  logic [FW-1:0]              x_idx, y_idx;
  logic [PIXEL_WIDTH-1:0]     pred;
  logic [DW-1:0]              diff;
  logic [MB_SIZE-1:0][DW-1:0] row_res;
  logic [SW-1:0]              row_abs_sum;

  function automatic logic [FW-1:0] clamp_idx(input logic signed [AW-1:0] v);
    if (v[AW-1]) begin
      return '0;
    end else if (v > COORD_MAX) begin
      return FW'(REF_FRAME_SIZE - 1);
    end else begin
      return v[FW-1:0];
    end
  endfunction

  // Row datapath: LOAD builds row 0, OUT builds the row following the current beat.
  always_comb begin
    row_sel     = (state_q == ST_LOAD) ? '0 : RW'(row_q + RW'(1));
    y_s         = $signed(AW'(mb_y_q)) + AW'(mv_y_q) + $signed(AW'(row_sel));
    y_idx       = clamp_idx(y_s);
    x_s         = '0;
    x_idx       = '0;
    pred        = '0;
    diff        = '0;
    row_res     = '0;
    row_abs_sum = '0;
    for (int j = 0; j < MB_SIZE; j++) begin
      x_s   = $signed(AW'(mb_x_q)) + AW'(mv_x_q) + AW'(j);
      x_idx = clamp_idx(x_s);
      pred  = ref_frame[y_idx][x_idx];
      diff  = DW'(curr_q[row_sel][j]) - DW'(pred);
      if (mode_q) begin
        row_res[j] = {1'b0, pred};
      end else begin
        row_res[j]  = diff;
        row_abs_sum = row_abs_sum + SW'(diff[DW-1] ? DW'(-diff) : diff);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    src_ready_d = src_ready_q;
    dst_valid_d = dst_valid_q;
    dst_last_d  = dst_last_q;
    row_d       = row_q;
    res_d       = res_q;
    sad_d       = sad_q;
    mb_x_d      = mb_x_q;
    mb_y_d      = mb_y_q;
    mv_x_d      = mv_x_q;
    mv_y_d      = mv_y_q;
    mode_d      = mode_q;
    curr_d      = curr_q;
    case (state_q)
      ST_IDLE: begin
        if (src_valid) begin
          mb_x_d      = mb_x;
          mb_y_d      = mb_y;
          mv_x_d      = mv_x;
          mv_y_d      = mv_y;
          mode_d      = mode;
          curr_d      = curr_mb;
          sad_d       = '0;
          src_ready_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        row_d       = '0;
        res_d       = row_res;
        sad_d       = row_abs_sum;
        dst_valid_d = 1'b1;
        dst_last_d  = 1'b0;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (dst_ready) begin
          if (row_q == RW'(MB_SIZE - 1)) begin
            dst_valid_d = 1'b0;
            dst_last_d  = 1'b0;
            src_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            row_d      = row_sel;
            res_d      = row_res;
            sad_d      = sad_q + row_abs_sum;
            dst_last_d = (row_sel == RW'(MB_SIZE - 1));
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        src_ready_d = 1'b1;
        dst_valid_d = 1'b0;
        dst_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      src_ready_q <= 1'b1;
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
      row_q       <= '0;
      res_q       <= '0;
      sad_q       <= '0;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      mode_q      <= 1'b0;
      curr_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_ready_q <= src_ready_d;
      dst_valid_q <= dst_valid_d;
      dst_last_q  <= dst_last_d;
      row_q       <= row_d;
      res_q       <= res_d;
      sad_q       <= sad_d;
      mb_x_q      <= mb_x_d;
      mb_y_q      <= mb_y_d;
      mv_x_q      <= mv_x_d;
      mv_y_q      <= mv_y_d;
      mode_q      <= mode_d;
      curr_q      <= curr_d;
    end
  end

  assign src_ready    = src_ready_q;
  assign dst_valid    = dst_valid_q;
  assign dst_last     = dst_last_q;
  assign dst_row      = row_q;
  assign residual_row = res_q;
  assign sad          = sad_q;

endmodule

// File: tb/tb_mc_residual_stream.sv
// Directed bench for mc_residual_stream: a reference model fills a beat scoreboard
// per job; beats are popped and checked as the DUT transfers them.
module tb_mc_residual_stream;

  logic                  clk;
  logic                  reset;
  logic                  src_valid;
  logic                  src_ready;
  logic [2:0]            mb_x, mb_y;
  logic signed [5:0]     mv_x, mv_y;
  logic                  mode;
  logic [7:0][7:0][7:0]  ref_frame;
  logic [3:0][3:0][7:0]  curr_mb;
  logic                  dst_valid;
  logic                  dst_ready;
  logic [1:0]            dst_row;
  logic                  dst_last;
  logic [3:0][8:0]       residual_row;
  logic [11:0]           sad;

  typedef struct {
    logic [1:0]  row;
    logic        last;
    logic [35:0] data;
    logic [11:0] sad;
  } beat_t;

  beat_t       exp_q[$];
  int          refm[8][8];
  int          currm[4][4];
  logic [35:0] got_data[4];
  logic [11:0] got_sad;
  int          tests = 0;
  int          fails = 0;
  int          nbeats, span;

  mc_residual_stream dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .mb_x(mb_x), .mb_y(mb_y), .mv_x(mv_x), .mv_y(mv_y), .mode(mode),
    .ref_frame(ref_frame), .curr_mb(curr_mb),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_row(dst_row),
    .dst_last(dst_last), .residual_row(residual_row), .sad(sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frames();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) ref_frame[i][j] = 8'(refm[i][j]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) curr_mb[i][j] = 8'(currm[i][j]);
  endtask

  // Reference model: edge-clamped fetch and residual/prediction per row.
  task automatic push_job(input int mbx, input int mby, input int mvx, input int mvy, input bit md);
    beat_t b;
    int sacc, x, y, p, v;
    sacc = 0;
    for (int r = 0; r < 4; r++) begin
      b.data = '0;
      for (int j = 0; j < 4; j++) begin
        x = mbx + mvx + j;
        y = mby + mvy + r;
        x = (x < 0) ? 0 : ((x > 7) ? 7 : x);
        y = (y < 0) ? 0 : ((y > 7) ? 7 : y);
        p = refm[y][x];
        v = md ? p : (currm[r][j] - p);
        if (!md) sacc += (v < 0) ? -v : v;
        b.data[j*9 +: 9] = 9'(v);
      end
      b.row  = 2'(r);
      b.last = (r == 3);
      b.sad  = md ? 12'd0 : 12'(sacc);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_job(input int mbx, input int mby, input int mvx, input int mvy, input bit md);
    load_frames();
    push_job(mbx, mby, mvx, mvy, md);
    mb_x = 3'(mbx);
    mb_y = 3'(mby);
    mv_x = 6'(mvx);
    mv_y = 6'(mvy);
    mode = md;
    check("src_ready_idle", 64'(src_ready), 64'd1);
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    check("src_ready_after_accept", 64'(src_ready), 64'd0);
    check("dst_valid_load", 64'(dst_valid), 64'd0);
    tick();
    check("dst_valid_2cyc", 64'(dst_valid), 64'd1);
  endtask

  // pat 0: dst_ready always 1; pat 1: dst_ready toggles 1,0,...
  task automatic collect(input int pat, output int nb, output int sp);
    beat_t e;
    bit stalled_prev;
    logic [50:0] prev;
    int first_c, last_c, c;
    nb = 0;
    first_c = -1;
    last_c = -1;
    stalled_prev = 1'b0;
    prev = '0;
    c = 0;
    while (exp_q.size() > 0 && c < 64) begin
      dst_ready = (pat == 0) || (c % 2 == 0);
      if (stalled_prev)
        check("hold_stable", 64'({dst_row, dst_last, sad, residual_row}), 64'(prev));
      if (dst_valid) begin
        check("src_ready_busy", 64'(src_ready), 64'd0);
        if (dst_ready) begin
          e = exp_q.pop_front();
          check("beat_row", 64'(dst_row), 64'(e.row));
          check("beat_last", 64'(dst_last), 64'(e.last));
          check("beat_data", 64'(residual_row), 64'(e.data));
          if (e.last) begin
            check("beat_sad", 64'(sad), 64'(e.sad));
            got_sad = sad;
          end
          if (nb < 4) got_data[nb] = residual_row;
          if (first_c < 0) first_c = c;
          last_c = c;
          nb++;
        end
      end
      stalled_prev = dst_valid && !dst_ready;
      prev = {dst_row, dst_last, sad, residual_row};
      tick();
      c++;
    end
    dst_ready = 1'b0;
    check("beats_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    sp = last_c - first_c + 1;
    check("dst_valid_after_last", 64'(dst_valid), 64'd0);
    check("src_ready_after_last", 64'(src_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    src_valid = 1'b0;
    dst_ready = 1'b0;
    mb_x = '0; mb_y = '0; mv_x = '0; mv_y = '0; mode = 1'b0;
    ref_frame = '0;
    curr_mb = '0;
    got_sad = '0;
    tick();
    tick();
    check("rst_dst_valid", 64'(dst_valid), 64'd0);
    check("rst_dst_last", 64'(dst_last), 64'd0);
    check("rst_dst_row", 64'(dst_row), 64'd0);
    check("rst_residual", 64'(residual_row), 64'd0);
    check("rst_sad", 64'(sad), 64'd0);
    check("rst_src_ready", 64'(src_ready), 64'd1);
    reset = 1'b1;
    tick();

    // 1: ramp reference, flat current block
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) refm[i][j] = 8 * i + j;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) currm[i][j] = 100;
    drive_job(0, 0, 0, 0, 1'b0);
    collect(0, nbeats, span);
    check("t1_row0", 64'(got_data[0]), 64'({9'd97, 9'd98, 9'd99, 9'd100}));
    check("t1_row3", 64'(got_data[3]), 64'({9'd73, 9'd74, 9'd75, 9'd76}));
    check("t1_sad", 64'(got_sad), 64'd1384);

    // 2: exact match with mv(1,1), back-to-back beats
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) currm[i][j] = 8 * (i + 1) + j + 1;
    drive_job(0, 0, 1, 1, 1'b0);
    collect(0, nbeats, span);
    check("t2_beats", 64'(nbeats), 64'd4);
    check("t2_span", 64'(span), 64'd4);
    check("t2_sad", 64'(got_sad), 64'd0);
    check("t2_row2", 64'(got_data[2]), 64'd0);

    // 3: clamping on both axes, prediction mode
    drive_job(4, 4, 3, -6, 1'b1);
    collect(0, nbeats, span);
    check("t3_row0", 64'(got_data[0]), 64'({9'd7, 9'd7, 9'd7, 9'd7}));
    check("t3_row2", 64'(got_data[2]), 64'({9'd7, 9'd7, 9'd7, 9'd7}));
    check("t3_row3", 64'(got_data[3]), 64'({9'd15, 9'd15, 9'd15, 9'd15}));
    check("t3_sad", 64'(got_sad), 64'd0);

    // 4: most negative residual
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) refm[i][j] = 255;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) currm[i][j] = 0;
    drive_job(0, 0, 0, 0, 1'b0);
    collect(0, nbeats, span);
    check("t4_row1", 64'(got_data[1]), 64'({9'h101, 9'h101, 9'h101, 9'h101}));
    check("t4_sad", 64'(got_sad), 64'd4080);

    // 5: toggling backpressure
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) refm[i][j] = 8 * i + j;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) currm[i][j] = 100;
    drive_job(2, 1, -1, 2, 1'b0);
    collect(1, nbeats, span);
    check("t5_beats", 64'(nbeats), 64'd4);
    check("t5_span", 64'(span), 64'd7);

    // 6: reset mid-block, then a clean job
    drive_job(0, 0, 0, 0, 1'b0);
    dst_ready = 1'b1;
    check("t6_row0", 64'(dst_row), 64'd0);
    tick();
    check("t6_row1", 64'(dst_row), 64'd1);
    tick();
    dst_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    check("t6_dst_valid", 64'(dst_valid), 64'd0);
    check("t6_src_ready", 64'(src_ready), 64'd1);
    check("t6_sad", 64'(sad), 64'd0);
    check("t6_dst_row", 64'(dst_row), 64'd0);
    drive_job(0, 0, 0, 0, 1'b0);
    collect(0, nbeats, span);
    check("t6_resume_sad", 64'(got_sad), 64'd1384);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
